// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU writeback stage: opcode encodings,
//            flag bit positions, the packed buffer entry and the per-opcode
//            flag normalisation helper.
// Contents : OP_ADD..OP_OR       3-bit ALU command encodings
//            FLAG_CARRY..NEG     bit indices into the 4-bit flags field
//            alu_entry_t         {result[31:0], flags[3:0], tag[ALU_TAG_W-1:0]}
//            alu_norm_flags()    flags as stored with an entry
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_SLT  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  localparam logic [2:0] OP_NOR  = 3'd6;
  localparam logic [2:0] OP_OR   = 3'd7;

  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_NEG   = 3;

  localparam int unsigned ALU_DATA_W  = 32;
  localparam int unsigned ALU_FLAGS_W = 4;
  // Tag width carried by the packed entry; the stage's TAG_W must match it.
  localparam int unsigned ALU_TAG_W   = 5;

  typedef struct packed {
    logic [ALU_DATA_W-1:0]  result;
    logic [ALU_FLAGS_W-1:0] flags;
    logic [ALU_TAG_W-1:0]   tag;
  } alu_entry_t;

  // Only arithmetic ops produce a meaningful carry; SLT keeps overflow
  // (it came from the internal subtract) but its result is a 0/1 boolean,
  // so its sign bit is not reported as negative. Logic ops clear both.
  function automatic logic [ALU_FLAGS_W-1:0] alu_norm_flags(
    input logic [2:0]            op,
    input logic [ALU_DATA_W-1:0] result,
    input logic                  carry,
    input logic                  ovf
  );
    logic [ALU_FLAGS_W-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = (result == '0);
    f[FLAG_NEG]  = result[ALU_DATA_W-1];
    case (op)
      OP_ADD, OP_SUB: begin
        f[FLAG_CARRY] = carry;
        f[FLAG_OVF]   = ovf;
      end
      OP_SLT: begin
        f[FLAG_OVF] = ovf;
        f[FLAG_NEG] = 1'b0;
      end
      default: ;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module   : alu_skid_fifo2
// Purpose  : Generic order-preserving 2-entry valid/ready buffer. The output
//            is driven straight from the head register, so out_data is a
//            flop output and stays stable while out_valid && !out_ready.
// Ports    : clk, rst_n             clock, async active-low reset
//            in_valid/in_ready      upstream handshake (in_ready = count != 2)
//            in_data[W-1:0]         entry to push
//            out_valid/out_ready    downstream handshake (out_valid = count != 0)
//            out_data[W-1:0]        head entry
//            pop                    commit strobe (out_valid && out_ready)
// Revision : 1.0  initial release
// ============================================================================
module alu_skid_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         pop
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = head_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b10: begin
            tail_d  = in_data;
            count_d = 2'd2;
          end
          2'b01: count_d = 2'd0;
          // Head leaves and the new entry replaces it in the same cycle.
          2'b11: head_d = in_data;
          default: ;
        endcase
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Registered writeback stage behind the 32-bit ALU. Normalises the
//            ALU flags per opcode at push, buffers up to two results in order,
//            and on every commit updates a status register and a saturating
//            transaction counter.
// Ports    : clk, rst_n                   clock, async active-low reset
//            in_valid/in_ready            upstream handshake
//            in_result, in_carry, in_ovf,
//            in_zero, in_op, in_tag       ALU outputs and destination tag
//            out_valid/out_ready          downstream handshake
//            out_result, out_flags,
//            out_tag                      head entry ({neg, zero, ovf, carry})
//            stat_flags                   flags of the last committed entry
//            op_count                     saturating commit counter
//            ovf_clr, stat_sticky_ovf     sticky overflow clear / status
// Config   : ALU_STICKY_OVF_EN  when defined, stat_sticky_ovf sets on any
//            committed overflow and clears on ovf_clr (set wins). When
//            undefined it is tied to 0 and ovf_clr is ignored.
// Revision : 1.0  initial release
// ============================================================================
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = ALU_TAG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_carry,
  input  logic             in_ovf,
  input  logic             in_zero,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       stat_flags,
  output logic [CNT_W-1:0] op_count,
  input  logic             ovf_clr,
  output logic             stat_sticky_ovf
);

  alu_entry_t push_entry;
  alu_entry_t head_entry;
  logic       pop;

  always_comb begin
    push_entry        = '0;
    push_entry.result = in_result;
    push_entry.flags  = alu_norm_flags(in_op, in_result, in_carry, in_ovf);
    push_entry.tag    = in_tag;
  end

  alu_skid_fifo2 #(
    .W ($bits(alu_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry),
    .pop       (pop)
  );

  assign out_result = head_entry.result;
  assign out_flags  = head_entry.flags;
  assign out_tag    = head_entry.tag;

  // --------------------------------------------------------------------------
  // Commit-side status and counter
  // --------------------------------------------------------------------------
  logic [3:0]       stat_flags_q, stat_flags_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  always_comb begin
    stat_flags_d = stat_flags_q;
    op_count_d   = op_count_q;
    if (pop) begin
      stat_flags_d = head_entry.flags;
      // Saturate rather than wrap so consumers never see the count go back.
      if (op_count_q != '1) begin
        op_count_d = op_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flags_q <= '0;
      op_count_q   <= '0;
    end else begin
      stat_flags_q <= stat_flags_d;
      op_count_q   <= op_count_d;
    end
  end

  assign stat_flags = stat_flags_q;
  assign op_count   = op_count_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_ovf_q, sticky_ovf_d;

  always_comb begin
    sticky_ovf_d = sticky_ovf_q;
    if (ovf_clr) begin
      sticky_ovf_d = 1'b0;
    end
    // Set is evaluated last so it wins over a same-cycle clear.
    if (pop && head_entry.flags[FLAG_OVF]) begin
      sticky_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf_q <= 1'b0;
    end else begin
      sticky_ovf_q <= sticky_ovf_d;
    end
  end

  assign stat_sticky_ovf = sticky_ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr  = ovf_clr;
  assign stat_sticky_ovf = 1'b0;
`endif

  // The ALU's own zero flag is redundant with the recomputed one; a
  // disagreement on an accepted push points at an upstream fault.
  a_zero_consistent : assert property (
    @(posedge clk) disable iff (!rst_n)
      (in_valid && in_ready) |-> (in_zero == (in_result == 32'd0))
  );

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered writeback stage directly downstream of the 32-bit ALU.
- Captures the ALU's combinational result and flags (carry, overflow, zero) with the opcode and a destination tag, under a valid/ready handshake.
- Buffers up to two results in an order-preserving skid buffer and normalises flags per opcode.
- Maintains a committed status register and a transaction counter for the register-file/branch logic that consumes it.

Parameters:
TAG_W, 5, destination tag width (register index).
CNT_W, 16, width of the committed-transaction counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream ALU result valid
in_ready  output  1  stage can accept this cycle
in_result  input  32  ALU result
in_carry  input  1  ALU carry flag
in_ovf  input  1  ALU overflow flag
in_zero  input  1  ALU zero flag
in_op  input  3  ALU command (0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR)
in_tag  input  TAG_W  destination tag
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_result  output  32  head result
out_flags  output  4  head flags {neg, zero, ovf, carry}
out_tag  output  TAG_W  head tag
stat_flags  output  4  flags of last committed entry
op_count  output  CNT_W  committed-transaction count, saturating
ovf_clr  input  1  clear sticky overflow (optional feature)
stat_sticky_ovf  output  1  sticky overflow (optional feature)

Behaviour:
- Reset is asynchronous and active-low on rst_n, sampled on clk.
  - Reset values: buffer empty; out_valid=0; in_ready=1; out_result=0; out_flags=0; out_tag=0; stat_flags=0; op_count=0; stat_sticky_ovf=0.
  - Reset mid-operation discards all buffered entries without committing them.
- All in_* signals must be settled by the clock edge. The clock period is chosen to exceed worst-case ALU ripple delay.
- Push occurs when in_valid && in_ready. Pop (commit) occurs when out_valid && out_ready.
- Storage is a 2-entry FIFO with count 0..2.
  - in_ready = (count != 2), combinational from registered count.
  - out_valid = (count != 0).
  - out_* are driven from the head entry register.
- Latency: an entry pushed at edge N is visible on out_* in cycle N+1 when the buffer was empty. Throughput is one entry per cycle while out_ready=1.
- Simultaneous push and pop:
  - count=1: count stays 1; new entry becomes head after the pop.
  - count=2: push is impossible because in_ready=0.
  - count=0: pop is impossible; push only.
- Pop on empty and push on full are never performed; out_valid and in_ready gate them.
- Flag normalisation is applied at push and stored with the entry:
  - ADD/SUB: carry and ovf pass through.
  - SLT: carry=0; ovf passes through.
  - XOR/AND/NAND/NOR/OR: carry=0, ovf=0.
  - zero is recomputed as (in_result==0); in_zero is used only for the assertion check below.
  - neg = in_result[31], except neg=0 for SLT.
- Assertion (simulation only): on push, in_zero == (in_result==0).
- Commit effects:
  - stat_flags <= head flags.
  - op_count increments and saturates at all-ones; it never wraps.
- out_* are held stable while out_valid && !out_ready.

Optional Feature:
ALU_STICKY_OVF_EN
- Defined:
  - stat_sticky_ovf sets on any commit whose ovf=1.
  - Clears on the cycle ovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined: stat_sticky_ovf is constant 0 and ovf_clr is ignored. Ports remain present.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD..OP_OR (3-bit);
  - flag bit indices FLAG_CARRY=0, FLAG_OVF=1, FLAG_ZERO=2, FLAG_NEG=3;
  - a packed entry type {result, flags, tag}.
- Sub-module alu_skid_fifo2: the generic 2-entry valid/ready FIFO over the packed entry.
- Flag normalisation, status register and counter stay in the top module.

Test Plan:
- Single push, out_ready=1: ADD, result 0x0000000B, carry=0, ovf=0, tag 3 -> out_valid in the next cycle; out_flags=0000; tag 3; op_count=1.
- SUB, result 0xFFFFFFFF, carry=0 -> out_flags neg=1, zero=0; after commit stat_flags=1000.
- XOR, result 0, in_carry=1, in_ovf=1 -> out_flags=0100, with carry and ovf masked.
- Backpressure: out_ready=0, push 3 entries in a row -> third held off by in_ready=0 after count=2; release out_ready -> entries commit in order with tags 1, 2, 3.
- Reset asserted with count=2 -> out_valid=0 immediately, in_ready=1, op_count=0; no commit recorded.
- ALU_STICKY_OVF_EN defined: commit ADD 0x7FFFFFFF+1 with ovf=1 -> sticky=1. Then ovf_clr=1 together with another ovf commit -> sticky stays 1. Then ovf_clr alone -> sticky=0.
